// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream input and instruction-memory / CPU-control outputs of the boot loader.
// Latency: none, wires only.
// Backpressure: none; the receiver strobes bytes and the loader always takes them.
interface program_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic                  cpu_run;
    logic                  done;
    logic                  error;
    logic [ADDR_WIDTH:0]   words_loaded;

    // Loader side: consumes the byte stream, drives memory writes and CPU control.
    modport master (
        input  rx_data, rx_valid,
        output imem_we, imem_addr, imem_wdata, cpu_run, done, error, words_loaded
    );

    // System side: supplies bytes, observes memory writes and CPU control.
    modport slave (
        output rx_data, rx_valid,
        input  imem_we, imem_addr, imem_wdata, cpu_run, done, error, words_loaded
    );
endinterface

// File: rtl/program_loader.sv
// program_loader: assembles a length-prefixed big-endian byte stream into instruction memory, then releases the CPU.
// Latency: imem write 1 cycle after a word's 4th byte; cpu_run/done/error 1 cycle after the deciding byte or timeout.
// Backpressure: none, every rx_valid byte is taken; LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte.
module program_loader #(
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic             clock,
    input  logic             reset_n,
    program_loader_if.master bus
);
    localparam int unsigned MAX_WORDS = 32'd1 << ADDR_WIDTH;
    // The counter only ever needs to hold TIMEOUT_CYCLES-1; the next idle edge is the timeout.
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_RUN,
        S_ERROR
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            len_hi_q;
    logic [15:0]           n_q;
    logic [23:0]           asm_q;      // first three bytes of the word; the 4th goes straight to imem_wdata
    logic [1:0]            idx_q;
    logic [TW-1:0]         cnt_q;
    logic                  imem_we_q;
    logic [31:0]           imem_wdata_q;
    logic                  cpu_run_q;
    logic                  done_q;
    logic                  error_q;
    logic [ADDR_WIDTH:0]   words_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            sum_q;
    logic [7:0]            ck_total;
`endif

    logic                  accept;
    logic                  timed;
    logic                  timeout_hit;
    logic                  word_done;
    logic                  last_word;
    logic                  len_bad;
    logic [15:0]           n_new;

    // Next-state decode: which byte is being taken, whether a word completes, and where the frame goes next.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        timed       = 1'b0;
        word_done   = 1'b0;
        n_new       = {len_hi_q, bus.rx_data};
        len_bad     = (n_new == 16'd0) || (32'(n_new) > MAX_WORDS);
        // words_q has not yet counted the word completing now, hence the +1.
        last_word   = (32'(words_q) + 32'd1) == 32'(n_q);
`ifdef LOADER_CHECKSUM_EN
        ck_total    = sum_q + bus.rx_data;
`endif
        case (state_q)
            S_LEN_HI: begin
                accept = bus.rx_valid;
                if (bus.rx_valid) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                timed  = 1'b1;
                accept = bus.rx_valid;
                if (bus.rx_valid) state_d = len_bad ? S_ERROR : S_DATA;
            end
            S_DATA: begin
                timed  = 1'b1;
                accept = bus.rx_valid;
                if (bus.rx_valid && idx_q == 2'd3) begin
                    word_done = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    if (last_word) state_d = S_CHECK;
`else
                    if (last_word) state_d = S_RUN;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                timed  = 1'b1;
                accept = bus.rx_valid;
                if (bus.rx_valid) state_d = (ck_total == 8'd0) ? S_RUN : S_ERROR;
            end
`endif
            default: ;
        endcase
        // A byte in the timeout cycle wins, so the timeout only fires on an idle edge.
        timeout_hit = (TIMEOUT_CYCLES != 0) && timed && !bus.rx_valid && (cnt_q == TO_LAST);
        if (timeout_hit) state_d = S_ERROR;
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_LEN_HI;
        else          state_q <= state_d;
    end

    // Datapath: length latch, word assembly, write pulse, word count, idle counter and registered status.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            len_hi_q     <= '0;
            n_q          <= '0;
            asm_q        <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            imem_we_q    <= 1'b0;
            imem_wdata_q <= '0;
            cpu_run_q    <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            words_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            imem_we_q <= word_done;
            if (word_done) imem_wdata_q <= {asm_q, bus.rx_data};
            if (imem_we_q) words_q <= words_q + (ADDR_WIDTH+1)'(1);
            if (accept && state_q == S_LEN_HI) len_hi_q <= bus.rx_data;
            if (accept && state_q == S_LEN_LO) n_q <= n_new;
            if (accept && state_q == S_DATA) begin
                asm_q <= {asm_q[15:0], bus.rx_data};
                idx_q <= idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                sum_q <= sum_q + bus.rx_data;
`endif
            end
            if (accept)                   cnt_q <= '0;
            else if (timed && !timeout_hit) cnt_q <= cnt_q + TW'(1);
            cpu_run_q <= (state_d == S_RUN);
            done_q    <= (state_d == S_RUN);
            error_q   <= (state_d == S_ERROR);
        end
    end

    assign bus.imem_we      = imem_we_q;
    assign bus.imem_addr    = words_q[ADDR_WIDTH-1:0];
    assign bus.imem_wdata   = imem_wdata_q;
    assign bus.cpu_run      = cpu_run_q;
    assign bus.done         = done_q;
    assign bus.error        = error_q;
    assign bus.words_loaded = words_q;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: drives frames into program_loader and checks memory writes and status against a frame-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_program_loader;
    localparam int AW = 10;
    localparam int TO = 16;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    program_loader_if #(.ADDR_WIDTH(AW)) bus();
    program_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int          wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];

    logic [7:0]  frame_q[$];
    logic [31:0] exp_words[$];
    bit          exp_done, exp_err;

    always @(posedge clock) cyc <= cyc + 1;

    // Record every write pulse seen on the memory port.
    always @(negedge clock) begin
        if (bus.imem_we === 1'b1) begin
            wr_addr.push_back(int'(bus.imem_addr));
            wr_data.push_back(bus.imem_wdata);
            wr_cyc.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    task automatic do_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        reset_n      = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        clear_log();
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clock);
            bus.rx_valid = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
    endtask

    // Sends frame_q with random idle gaps; returns at the negedge after the last byte was sampled.
    task automatic send_frame(input int gap_max, input int lead_max);
        if (lead_max > 0) idle($urandom_range(lead_max, 0));
        foreach (frame_q[i]) begin
            if (gap_max > 0 && i > 0) idle($urandom_range(gap_max, 0));
            send_byte(frame_q[i]);
        end
        @(negedge clock);
        bus.rx_valid = 1'b0;
    endtask

    task automatic add_checksum(input bit corrupt);
        logic [7:0] s;
        logic [7:0] c;
        s = 8'h00;
        for (int i = 2; i < frame_q.size(); i++) s = s + frame_q[i];
        c = 8'h00 - s;
        if (corrupt) c = c + 8'($urandom_range(255, 1));
        frame_q.push_back(c);
    endtask

    // Frame-level prediction: the words that must land in memory and the final verdict.
    task automatic model_frame();
        int          n;
        int unsigned sum;
        exp_words.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        n = int'({frame_q[0], frame_q[1]});
        if (n == 0 || n > (1 << AW)) begin
            exp_err = 1'b1;
            return;
        end
        sum = 0;
        for (int w = 0; w < n; w++) begin
            exp_words.push_back({frame_q[2+4*w], frame_q[3+4*w], frame_q[4+4*w], frame_q[5+4*w]});
            for (int k = 0; k < 4; k++) sum += frame_q[2+4*w+k];
        end
`ifdef LOADER_CHECKSUM_EN
        if (((sum + frame_q[2+4*n]) % 256) == 0) exp_done = 1'b1;
        else                                     exp_err  = 1'b1;
`else
        exp_done = 1'b1;
`endif
    endtask

    task automatic check_frame(input string name);
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if (wr_addr.size() !== exp_words.size()) begin
            errors++;
            $display("FAIL %s write_count: got %0d expected %0d", name, wr_addr.size(), exp_words.size());
        end
        for (int i = 0; i < exp_words.size() && i < wr_addr.size(); i++) begin
            checks++;
            if (wr_addr[i] !== i) begin
                errors++;
                $display("FAIL %s addr[%0d]: got %0d expected %0d", name, i, wr_addr[i], i);
            end
            checks++;
            if (wr_data[i] !== exp_words[i]) begin
                errors++;
                $display("FAIL %s data[%0d]: got %08h expected %08h", name, i, wr_data[i], exp_words[i]);
            end
        end
        checks++;
        if (int'(bus.words_loaded) !== exp_words.size()) begin
            errors++;
            $display("FAIL %s words_loaded: got %0d expected %0d", name, bus.words_loaded, exp_words.size());
        end
        checks++;
        if (bus.done !== exp_done || bus.cpu_run !== exp_done) begin
            errors++;
            $display("FAIL %s done/cpu_run: got %b/%b expected %b", name, bus.done, bus.cpu_run, exp_done);
        end
        checks++;
        if (bus.error !== exp_err) begin
            errors++;
            $display("FAIL %s error: got %b expected %b", name, bus.error, exp_err);
        end
    endtask

    task automatic test_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        reset_n      = 1'b0;
        @(negedge clock);
        checks++;
        if ({bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.cpu_run, bus.done, bus.error, bus.words_loaded} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b addr=%0d wdata=%08h run=%b done=%b err=%b words=%0d expected all 0",
                     bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.cpu_run, bus.done, bus.error, bus.words_loaded);
        end
        @(negedge clock);
        reset_n = 1'b1;
        clear_log();
    endtask

    task automatic test_normal();
        do_reset();
        frame_q = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h01};
`ifdef LOADER_CHECKSUM_EN
        add_checksum(1'b0);
`endif
        model_frame();
        send_frame(0, 0);
        checks++;
`ifdef LOADER_CHECKSUM_EN
        if (bus.cpu_run !== 1'b1 || bus.imem_we !== 1'b0) begin
            errors++;
            $display("FAIL normal_release: got run=%b we=%b expected run=1 we=0", bus.cpu_run, bus.imem_we);
        end
`else
        if (bus.cpu_run !== 1'b1 || bus.imem_we !== 1'b1) begin
            errors++;
            $display("FAIL normal_release: got run=%b we=%b expected run=1 we=1", bus.cpu_run, bus.imem_we);
        end
`endif
        check_frame("normal");
        checks++;
        if (wr_data.size() != 2 || wr_data[0] !== 32'hDEADBEEF || wr_data[1] !== 32'h00000001) begin
            errors++;
            $display("FAIL normal_words: got %0d writes expected DEADBEEF,00000001", wr_data.size());
        end
        checks++;
        if (wr_cyc.size() != 2 || wr_cyc[1] - wr_cyc[0] != 4) begin
            errors++;
            $display("FAIL normal_cadence: got %0d writes expected 2 writes 4 cycles apart", wr_cyc.size());
        end
    endtask

    task automatic test_bad_len();
        logic [15:0] n;
        for (int t = 0; t < 3; t++) begin
            do_reset();
            if (t == 0)      n = 16'h0000;
            else if (t == 1) n = 16'h0401;
            else             n = 16'($urandom_range(65535, 1025));
            frame_q = '{n[15:8], n[7:0]};
            model_frame();
            send_byte(frame_q[0]);
            @(negedge clock);
            checks++;
            if (bus.error !== 1'b0) begin
                errors++;
                $display("FAIL bad_len_early n=%0d: got error=%b expected 0", n, bus.error);
            end
            bus.rx_data = frame_q[1];
            @(negedge clock);
            bus.rx_valid = 1'b0;
            checks++;
            if (bus.error !== 1'b1 || bus.cpu_run !== 1'b0) begin
                errors++;
                $display("FAIL bad_len n=%0d: got error=%b run=%b expected error=1 run=0", n, bus.error, bus.cpu_run);
            end
            check_frame("bad_len");
        end
    endtask

    task automatic test_max_len();
        do_reset();
        frame_q = '{8'h04, 8'h00};
        for (int i = 0; i < 4096; i++) frame_q.push_back(8'(i));
`ifdef LOADER_CHECKSUM_EN
        add_checksum(1'b0);
`endif
        model_frame();
        send_frame(0, 0);
        check_frame("max_len");
        checks++;
        if (wr_addr.size() != 1024 || wr_addr[1023] !== 1023 || wr_data[1023] !== 32'hFCFDFEFF) begin
            errors++;
            $display("FAIL max_len_last: got %0d writes expected last addr 1023 data FCFDFEFF", wr_addr.size());
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hDE);
        idle(15);
        @(negedge clock);
        checks++;
        if (bus.error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got error=%b expected 0 after 15 idle cycles", bus.error);
        end
        @(negedge clock);
        checks++;
        if (bus.error !== 1'b1 || bus.cpu_run !== 1'b0) begin
            errors++;
            $display("FAIL timeout: got error=%b run=%b expected error=1 run=0", bus.error, bus.cpu_run);
        end
        frame_q = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        send_frame(0, 0);
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if (wr_addr.size() != 0 || bus.error !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: got writes=%0d error=%b done=%b expected 0/1/0", wr_addr.size(), bus.error, bus.done);
        end
    endtask

    task automatic test_timeout_race();
        do_reset();
        frame_q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef LOADER_CHECKSUM_EN
        add_checksum(1'b0);
`endif
        model_frame();
        for (int i = 0; i < 3; i++) send_byte(frame_q[i]);
        idle(15);
        for (int i = 3; i < frame_q.size(); i++) send_byte(frame_q[i]);
        @(negedge clock);
        bus.rx_valid = 1'b0;
        check_frame("timeout_race");
    endtask

    task automatic test_random();
        int n;
        for (int t = 0; t < 6; t++) begin
            do_reset();
            n = $urandom_range(12, 1);
            frame_q = '{8'(n >> 8), 8'(n)};
            for (int i = 0; i < 4 * n; i++) frame_q.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
            add_checksum(($urandom % 3) == 0);
`endif
            model_frame();
            send_frame(6, 40);
            check_frame("random");
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        for (int t = 0; t < 2; t++) begin
            do_reset();
            frame_q = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
            add_checksum(t == 1);
            model_frame();
            for (int i = 0; i < 6; i++) send_byte(frame_q[i]);
            @(negedge clock);
            checks++;
            if (bus.imem_we !== 1'b1 || bus.cpu_run !== 1'b0) begin
                errors++;
                $display("FAIL checksum_pre: got we=%b run=%b expected we=1 run=0", bus.imem_we, bus.cpu_run);
            end
            bus.rx_data = frame_q[6];
            @(negedge clock);
            bus.rx_valid = 1'b0;
            checks++;
            if (bus.cpu_run !== exp_done || bus.error !== exp_err) begin
                errors++;
                $display("FAIL checksum_release: got run=%b err=%b expected %b/%b", bus.cpu_run, bus.error, exp_done, exp_err);
            end
            check_frame("checksum");
        end
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        frame_q = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h11};
        send_frame(0, 0);
        checks++;
        if (bus.words_loaded !== 11'd1 || bus.imem_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL reset_mid_pre: got words=%0d wdata=%08h expected 1/DEADBEEF", bus.words_loaded, bus.imem_wdata);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.cpu_run, bus.done, bus.error, bus.words_loaded} !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: got wdata=%08h words=%0d expected all outputs 0", bus.imem_wdata, bus.words_loaded);
        end
        @(negedge clock);
        reset_n = 1'b1;
        clear_log();
        frame_q = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
`ifdef LOADER_CHECKSUM_EN
        add_checksum(1'b0);
`endif
        model_frame();
        send_frame(0, 0);
        check_frame("reset_mid");
        checks++;
        if (wr_data.size() != 1 || wr_data[0] !== 32'hCAFEBABE) begin
            errors++;
            $display("FAIL reset_mid_word: got %0d writes expected one CAFEBABE", wr_data.size());
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_bad_len();
        test_max_len();
        test_timeout();
        test_timeout_race();
        test_random();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
